// File: rtl/stopwatch_ctrl_if.sv
// Button/switch inputs and registered pulse/state outputs of stopwatch_ctrl.
// The slave modport is the controller side; the master modport is the board/bench side.
interface stopwatch_ctrl_if;
    logic       btn_pause;
    logic       btn_clr;
    logic       sw_adj;
    logic       sw_sel;
    logic       inc_sec;
    logic       inc_min;
    logic       clr;
    logic [1:0] state;
    logic       blink;

    modport master (
        output btn_pause, btn_clr, sw_adj, sw_sel,
        input  inc_sec, inc_min, clr, state, blink
    );

    modport slave (
        input  btn_pause, btn_clr, sw_adj, sw_sel,
        output inc_sec, inc_min, clr, state, blink
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces the buttons/switches, divides clk down to 1 Hz / 2 Hz
// ticks and drives the RUN/PAUSE/ADJ mode FSM. Define STOPWATCH_CTRL_BLINK_EN for the 2 Hz ADJ blink output.
module stopwatch_ctrl #(
    parameter int CLK_HZ     = 100000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave io
);
    localparam int DIV_W = $clog2(CLK_HZ);
    localparam int DEB_W = $clog2(DEB_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2 - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam int IN_PAUSE = 0;
    localparam int IN_CLR   = 1;
    localparam int IN_ADJ   = 2;
    localparam int IN_SEL   = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_ADJ   = 2'b10
    } state_e;

    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][DEB_W-1:0] cnt_q, cnt_d;
    logic                  press_pause_q, press_pause_d;
    logic                  press_clr_q, press_clr_d;
    logic [DIV_W-1:0]      div_q, div_d;
    state_e                state_q, state_d;
    logic                  inc_sec_q, inc_sec_d;
    logic                  inc_min_q, inc_min_d;
    logic                  clr_q, clr_d;
    logic                  tick1, tick2;

    // Input conditioning: the counter only runs while the synchronized level differs
    // from the accepted level, so any bounce back restarts it.
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sync1_d = {io.sw_sel, io.sw_adj, io.btn_clr, io.btn_pause};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
        press_pause_d = deb_d[IN_PAUSE] & ~deb_q[IN_PAUSE];
        press_clr_d   = deb_d[IN_CLR] & ~deb_q[IN_CLR];
    end

    always_comb begin
        tick1 = (div_q == DIV_LAST);
        tick2 = tick1 || (div_q == DIV_HALF);
        if (press_clr_q || tick1) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Adjust mode wins over a pause press accepted in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_PAUSE: begin
                if (deb_q[IN_ADJ]) begin
                    state_d = ST_ADJ;
                end else if (press_pause_q) begin
                    state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                end
            end
            ST_ADJ: begin
                if (!deb_q[IN_ADJ]) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        inc_sec_d = 1'b0;
        inc_min_d = 1'b0;
        clr_d     = press_clr_q;
        if (!press_clr_q) begin
            case (state_q)
                ST_RUN: inc_sec_d = tick1;
                ST_ADJ: begin
                    if (tick2) begin
                        if (deb_q[IN_SEL]) inc_sec_d = 1'b1;
                        else               inc_min_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            cnt_q         <= '0;
            press_pause_q <= 1'b0;
            press_clr_q   <= 1'b0;
            div_q         <= '0;
            state_q       <= ST_RUN;
            inc_sec_q     <= 1'b0;
            inc_min_q     <= 1'b0;
            clr_q         <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            cnt_q         <= cnt_d;
            press_pause_q <= press_pause_d;
            press_clr_q   <= press_clr_d;
            div_q         <= div_d;
            state_q       <= state_d;
            inc_sec_q     <= inc_sec_d;
            inc_min_q     <= inc_min_d;
            clr_q         <= clr_d;
        end
    end

    assign io.inc_sec = inc_sec_q;
    assign io.inc_min = inc_min_q;
    assign io.clr     = clr_q;
    assign io.state   = state_q;

`ifdef STOPWATCH_CTRL_BLINK_EN
    localparam int QTR = CLK_HZ / 4;
    localparam logic [DIV_W-1:0] DIV_Q1 = DIV_W'(QTR - 1);
    localparam logic [DIV_W-1:0] DIV_Q3 = DIV_W'(3 * QTR - 1);

    logic blink_q, blink_d;
    logic qtick;

    // Toggle on each quarter of the divider period; leaving ADJ clears it immediately.
    always_comb begin
        qtick   = (div_q == DIV_Q1) || (div_q == DIV_HALF) || (div_q == DIV_Q3) || tick1;
        blink_d = blink_q;
        if (state_d != ST_ADJ) begin
            blink_d = 1'b0;
        end else if (state_q == ST_ADJ && qtick) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) blink_q <= 1'b0;
        else     blink_q <= blink_d;
    end

    assign io.blink = blink_q;
`else
    assign io.blink = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (CLK_HZ=8, DEB_CYCLES=4): a behavioural model pushes the
// expected outputs for every clock edge, and a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;
    localparam int CLK_HZ = 8;
    localparam int DEB    = 4;
    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_ADJ   = 2;

    typedef struct packed {
        logic       sec;
        logic       min;
        logic       clr;
        logic [1:0] st;
        logic       blink;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    stopwatch_ctrl_if sif();

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .io  (sif.slave)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Reference model: inputs reach the debouncer two samples late; a level is accepted once
    // DEB consecutive synchronized samples agree on a value different from the current one.
    int m_div;
    int m_mode;
    int m_streak[4];
    bit m_s1[4], m_s2[4], m_deb[4], m_last[4];
    bit m_pp, m_pc, m_blink;

    always @(posedge clk) begin : model
        bit   raw[4];
        bit   nd[4];
        int   nmode;
        bit   t1, t2, tq;
        obs_t o;
        cyc++;
        raw = '{sif.btn_pause, sif.btn_clr, sif.sw_adj, sif.sw_sel};
        o = '0;
        if (rst) begin
            m_div = 0; m_mode = M_RUN; m_pp = 0; m_pc = 0; m_blink = 0;
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_last[i] = 0; m_streak[i] = 0;
            end
        end else begin
            t1 = (m_div == CLK_HZ - 1);
            t2 = (m_div % (CLK_HZ / 2)) == (CLK_HZ / 2 - 1);
            tq = (m_div % (CLK_HZ / 4)) == (CLK_HZ / 4 - 1);
            o.clr = m_pc;
            if (!m_pc) begin
                if (m_mode == M_RUN && t1) o.sec = 1'b1;
                if (m_mode == M_ADJ && t2) begin
                    if (m_deb[3]) o.sec = 1'b1;
                    else          o.min = 1'b1;
                end
            end
            nmode = m_mode;
            if (m_mode == M_ADJ) begin
                if (!m_deb[2]) nmode = M_RUN;
            end else if (m_deb[2]) begin
                nmode = M_ADJ;
            end else if (m_pp) begin
                nmode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
            end
            o.st = 2'(nmode);
`ifdef STOPWATCH_CTRL_BLINK_EN
            if (nmode != M_ADJ)                m_blink = 1'b0;
            else if (m_mode == M_ADJ && tq)    m_blink = ~m_blink;
`else
            m_blink = tq & 1'b0;
`endif
            o.blink = m_blink;
            m_div = m_pc ? 0 : (m_div + 1) % CLK_HZ;
            for (int i = 0; i < 4; i++) begin
                m_streak[i] = (m_s2[i] == m_last[i]) ? m_streak[i] + 1 : 1;
                m_last[i]   = m_s2[i];
                nd[i]       = m_deb[i];
                if (m_s2[i] != m_deb[i] && m_streak[i] >= DEB) nd[i] = m_s2[i];
            end
            m_pp = nd[0] & !m_deb[0];
            m_pc = nd[1] & !m_deb[1];
            m_deb = nd;
            m_s2  = m_s1;
            m_s1  = raw;
            m_mode = nmode;
        end
        exp_q.push_back(o);
    end

    always @(negedge clk) begin : monitor
        obs_t act;
        if (exp_q.size() > 0) begin
            act = {sif.inc_sec, sif.inc_min, sif.clr, sif.state, sif.blink};
            check(rst ? "reset_outputs sec/min/clr/st/blink" : "outputs sec/min/clr/st/blink",
                  32'(act), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_pause(int hold);
        sif.btn_pause = 1'b1;
        wait_cycles(hold);
        sif.btn_pause = 1'b0;
        wait_cycles(10);
    endtask

    task automatic press_clr(int hold);
        sif.btn_clr = 1'b1;
        wait_cycles(hold);
        sif.btn_clr = 1'b0;
        wait_cycles(8);
    endtask

    initial begin
        sif.btn_pause = 1'b0;
        sif.btn_clr   = 1'b0;
        sif.sw_adj    = 1'b0;
        sif.sw_sel    = 1'b0;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;

        // Idle run: inc_sec every CLK_HZ cycles.
        wait_cycles(30);

        // Pause and resume.
        press_pause(10);
        wait_cycles(20);
        press_pause(10);
        wait_cycles(20);

        // Bouncing pause button must never be accepted.
        for (int i = 0; i < 20; i++) begin
            sif.btn_pause = ~sif.btn_pause;
            wait_cycles(1);
        end
        sif.btn_pause = 1'b0;
        wait_cycles(12);

        // Adjust minutes, then seconds; pause presses ignored.
        sif.sw_adj = 1'b1;
        wait_cycles(30);
        sif.sw_sel = 1'b1;
        wait_cycles(20);
        press_pause(10);
        press_clr(6);
        sif.sw_adj = 1'b0;
        sif.sw_sel = 1'b0;
        wait_cycles(20);

        // Clear presses swept across every divider phase.
        for (int i = 0; i < CLK_HZ; i++) begin
            wait_cycles(i);
            press_clr(6);
        end

        // Clear while paused leaves the mode alone.
        press_pause(10);
        press_clr(6);
        press_pause(10);

        // Pause press and adjust switch accepted together: adjust wins.
        sif.btn_pause = 1'b1;
        sif.sw_adj    = 1'b1;
        wait_cycles(12);
        sif.btn_pause = 1'b0;
        wait_cycles(20);

        // Reset pulse in adjust mode, then recovery.
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(20);
        sif.sw_adj = 1'b0;
        wait_cycles(20);

        // Random button/switch activity with bursts of bouncing.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0)  sif.btn_pause = ~sif.btn_pause;
            if ($urandom_range(0, 5) == 0)  sif.btn_clr   = ~sif.btn_clr;
            if ($urandom_range(0, 39) == 0) sif.sw_adj    = ~sif.sw_adj;
            if ($urandom_range(0, 9) == 0)  sif.sw_sel    = ~sif.sw_sel;
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else                             rst = 1'b0;
            wait_cycles(1);
        end
        rst = 1'b0;
        sif.btn_pause = 1'b0;
        sif.btn_clr   = 1'b0;
        sif.sw_adj    = 1'b0;
        wait_cycles(20);

        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
